// File: rtl/msx_mouse_pkg.sv
// Shared types and constants for the MSX joystick-port mouse reader.
package msx_mouse_pkg;

   typedef enum logic [2:0] {
      ST_GAP,
      ST_TOGGLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   typedef logic [1:0] nib_idx_t;

   localparam int DEF_SETTLE_CYCLES   = 200;
   localparam int DEF_POLL_CYCLES     = 357954;
   localparam int MOUSE_RESYNC_CYCLES = 100000;

endpackage

// File: rtl/msx_pin_sync.sv
// Two-flop synchroniser for asynchronous port pins; data only, so no reset.
module msx_pin_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk_sys,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;

   always_ff @(posedge clk_sys) begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
   end

   assign q = sync_p1;

endmodule

// File: rtl/msx_mouse_reader.sv
// Host-side MSX mouse reader: four strobe toggles per frame, assembles dx/dy/buttons.
// Optional MSX_MOUSE_ACCUM_EN adds a clamped absolute-position accumulator on pos_x/pos_y.
module msx_mouse_reader
   import msx_mouse_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int POLL_CYCLES   = DEF_POLL_CYCLES,
   parameter int X_MAX         = 511,
   parameter int Y_MAX         = 383
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       enable,
   input  logic [5:0] joy_in,
   output logic       stra,
   output logic [7:0] dx,
   output logic [7:0] dy,
   output logic [1:0] buttons,
   output logic       valid,
   output logic       busy,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y
);

   localparam int CNT_MAX = (POLL_CYCLES > SETTLE_CYCLES) ? POLL_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   generate
      if (SETTLE_CYCLES < 1 || X_MAX < 0 || X_MAX > 1023 || Y_MAX < 0 || Y_MAX > 1023) begin : g_param_check
         $error("msx_mouse_reader: SETTLE_CYCLES must be >=1 and X_MAX/Y_MAX must fit 10 bits");
      end
   endgenerate

   logic [5:0]       joy_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   nib_idx_t         idx_q, idx_d;
   logic [11:0]      nib_sr;

   msx_pin_sync #(.WIDTH(6)) u_joy_sync (
      .clk_sys (clk_sys),
      .d       (joy_in),
      .q       (joy_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      case (state_q)
         ST_GAP: begin
            if (cnt_q != '0)
               cnt_d = cnt_q - CNT_W'(1);
            else if (enable)
               state_d = ST_TOGGLE;
         end
         ST_TOGGLE: begin
            cnt_d   = CNT_W'(SETTLE_CYCLES);
            state_d = (SETTLE_CYCLES == 1) ? ST_SAMPLE : ST_SETTLE;
         end
         // counter holds SETTLE_CYCLES on the first settle cycle, so leave at 2
         ST_SETTLE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(2))
               state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            idx_d   = idx_q + 2'd1;
            state_d = (idx_q == 2'd3) ? ST_DONE : ST_TOGGLE;
         end
         ST_DONE: begin
            cnt_d   = CNT_W'(POLL_CYCLES);
            idx_d   = '0;
            state_d = ST_GAP;
         end
         default: begin
            cnt_d   = CNT_W'(POLL_CYCLES);
            idx_d   = '0;
            state_d = ST_GAP;
         end
      endcase
   end

   // stra flips on the edge entering TOGGLE so it is visible in the TOGGLE cycle itself
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= ST_GAP;
         cnt_q   <= CNT_W'(POLL_CYCLES);
         idx_q   <= '0;
         stra    <= 1'b0;
         dx      <= '0;
         dy      <= '0;
         buttons <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         if (state_d == ST_TOGGLE)
            stra <= ~stra;
         if (state_q == ST_SAMPLE && idx_q == 2'd3) begin
            dx      <= nib_sr[11:4];
            dy      <= {nib_sr[3:0], joy_s[3:0]};
            buttons <= ~joy_s[5:4];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (state_q == ST_SAMPLE)
         nib_sr <= {nib_sr[7:0], joy_s[3:0]};
   end

   assign valid = (state_q == ST_DONE);
   assign busy  = (state_q == ST_TOGGLE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

`ifdef MSX_MOUSE_ACCUM_EN
   function automatic logic [9:0] clamp_pos(input logic signed [10:0] v, input int hi);
      if (v < 0)
         return '0;
      else if (v > hi)
         return 10'(hi);
      else
         return v[9:0];
   endfunction

   // MSX sense is + = left/up; screen sense needs subtraction
   logic signed [10:0] next_x, next_y;
   assign next_x = $signed({1'b0, pos_x}) - $signed({{3{dx[7]}}, dx});
   assign next_y = $signed({1'b0, pos_y}) - $signed({{3{dy[7]}}, dy});

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pos_x <= 10'(X_MAX / 2 + 1);
         pos_y <= 10'(Y_MAX / 2 + 1);
      end else if (state_q == ST_DONE) begin
         pos_x <= clamp_pos(next_x, X_MAX);
         pos_y <= clamp_pos(next_y, Y_MAX);
      end
   end
`else
   assign pos_x = '0;
   assign pos_y = '0;
`endif

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Directed bench for msx_mouse_reader with a behavioural MSX mouse on joy_in.
module tb_msx_mouse_reader;

   localparam int SETTLE = 4;
   localparam int POLL   = 50;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       enable;
   logic [5:0] joy_in;
   logic       stra;
   logic [7:0] dx, dy;
   logic [1:0] buttons;
   logic       valid, busy;
   logic [9:0] pos_x, pos_y;

   msx_mouse_reader #(
      .SETTLE_CYCLES (SETTLE),
      .POLL_CYCLES   (POLL),
      .X_MAX         (511),
      .Y_MAX         (383)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .enable  (enable),
      .joy_in  (joy_in),
      .stra    (stra),
      .dx      (dx),
      .dy      (dy),
      .buttons (buttons),
      .valid   (valid),
      .busy    (busy),
      .pos_x   (pos_x),
      .pos_y   (pos_y)
   );

   always #5 clk_sys = ~clk_sys;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Behavioural mouse: each strobe edge presents the next nibble; long idle resyncs to nibble 0
   logic [7:0] m_dx, m_dy;
   logic [1:0] m_btn_n;
   logic       m_off;
   logic       m_prev = 1'b0;
   logic [3:0] m_nib  = 4'hF;
   int         m_k    = 0;
   int         m_idle = 0;

   always @(negedge clk_sys) begin
      if (stra !== m_prev) begin
         m_prev = stra;
         if (m_idle > 30) m_k = 0;
         case (m_k)
            0: m_nib = m_dx[7:4];
            1: m_nib = m_dx[3:0];
            2: m_nib = m_dy[7:4];
            default: m_nib = m_dy[3:0];
         endcase
         m_k    = (m_k + 1) % 4;
         m_idle = 0;
      end else begin
         m_idle++;
      end
      joy_in = m_off ? 6'h3F : {m_btn_n, m_nib};
   end

   int   n_edges = 0;
   int   n_valid = 0;
   int   edge_cyc [16];
   logic mon_prev = 1'b0;

   always @(negedge clk_sys) begin
      if (!$isunknown(stra) && stra !== mon_prev) begin
         edge_cyc[n_edges % 16] = cyc;
         n_edges++;
      end
      mon_prev = stra;
      if (valid === 1'b1) n_valid++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic step();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int i;
      i = 0;
      do begin
         step();
         i++;
      end while (valid !== 1'b1 && i < 400);
      check({tag, "_valid_seen"}, {31'd0, valid}, 32'd1);
   endtask

   task automatic wait_edges(input int target, input string tag);
      int i;
      i = 0;
      while (n_edges < target && i < 400) begin
         step();
         i++;
      end
      check({tag, "_edge_seen"}, {31'd0, (n_edges >= target)}, 32'd1);
   endtask

   int ex_x [4];
   int ex_y [4];
   int pos_x0, pos_y0;
   int rel, vcyc, e0, e1, e2, e3, nv;

   initial begin
`ifdef MSX_MOUSE_ACCUM_EN
      ex_x   = '{384, 511, 511, 384};
      ex_y   = '{65, 0, 0, 0};
      pos_x0 = 256;
      pos_y0 = 192;
`else
      ex_x   = '{0, 0, 0, 0};
      ex_y   = '{0, 0, 0, 0};
      pos_x0 = 0;
      pos_y0 = 0;
`endif
      reset   = 1'b1;
      enable  = 1'b1;
      m_off   = 1'b0;
      m_dx    = 8'h12;
      m_dy    = 8'hF0;
      m_btn_n = 2'b10;
      joy_in  = 6'h3F;
      repeat (4) step();

      check("rst_stra",    {31'd0, stra},    32'd0);
      check("rst_valid",   {31'd0, valid},   32'd0);
      check("rst_busy",    {31'd0, busy},    32'd0);
      check("rst_dx",      {24'd0, dx},      32'd0);
      check("rst_dy",      {24'd0, dy},      32'd0);
      check("rst_buttons", {30'd0, buttons}, 32'd0);
      check("rst_pos_x",   {22'd0, pos_x},   pos_x0);
      check("rst_pos_y",   {22'd0, pos_y},   pos_y0);

      // Frame 1: data, strobe timing
      reset = 1'b0;
      rel   = cyc;
      e0    = n_edges;
      wait_valid("f1");
      vcyc = cyc;
      check("f1_dx",      {24'd0, dx},      32'h12);
      check("f1_dy",      {24'd0, dy},      32'hF0);
      check("f1_buttons", {30'd0, buttons}, 32'd1);
      check("f1_busy",    {31'd0, busy},    32'd0);
      check("f1_edges",   n_edges - e0,     32'd4);
      check("f1_stra",    {31'd0, stra},    32'd0);
      check("f1_first_gap", {31'd0, (edge_cyc[e0 % 16] - rel >= POLL)}, 32'd1);
      for (int k = 1; k < 4; k++)
         check("f1_edge_spacing", edge_cyc[(e0 + k) % 16] - edge_cyc[(e0 + k - 1) % 16], SETTLE + 1);
      check("f1_valid_latency", vcyc - edge_cyc[(e0 + 3) % 16], SETTLE + 1);
      step();
      check("f1_valid_pulse", {31'd0, valid}, 32'd0);

      // Frame 2: enable dropped mid-frame, frame still completes
      m_dx    = 8'h5A;
      m_dy    = 8'h3C;
      m_btn_n = 2'b01;
      wait_edges(e0 + 5, "f2_start");
      check("f2_poll_gap", {31'd0, (edge_cyc[(e0 + 4) % 16] - vcyc >= POLL)}, 32'd1);
      wait_edges(e0 + 6, "f2_nib1");
      step();
      step();
      enable = 1'b0;
      nv     = n_valid;
      wait_valid("f2");
      check("f2_dx",      {24'd0, dx},      32'h5A);
      check("f2_dy",      {24'd0, dy},      32'h3C);
      check("f2_buttons", {30'd0, buttons}, 32'd2);
      repeat (150) step();
      check("f2_no_more_edges", n_edges - e0, 32'd8);
      check("f2_one_valid",     n_valid - nv, 32'd1);
      check("f2_stra_idle",     {31'd0, stra}, 32'd0);

      // Reset mid-frame
      enable = 1'b1;
      e1     = n_edges;
      wait_edges(e1 + 1, "t4_first");
      step();
      reset = 1'b1;
      step();
      check("t4_stra",    {31'd0, stra},    32'd0);
      check("t4_valid",   {31'd0, valid},   32'd0);
      check("t4_busy",    {31'd0, busy},    32'd0);
      check("t4_dx",      {24'd0, dx},      32'd0);
      check("t4_dy",      {24'd0, dy},      32'd0);
      check("t4_buttons", {30'd0, buttons}, 32'd0);
      reset = 1'b0;
      rel   = cyc;
      e2    = n_edges;
      nv    = n_valid;
      wait_edges(e2 + 1, "t4_restart");
      check("t4_restart_gap", {31'd0, (edge_cyc[e2 % 16] - rel >= POLL)}, 32'd1);
      check("t4_no_valid",    n_valid - nv, 32'd0);
      wait_valid("t4_resync");
      check("t4_resync_dx", {24'd0, dx}, 32'h5A);
      check("t4_resync_dy", {24'd0, dy}, 32'h3C);

      // Accumulator sequence from the reset position
      reset = 1'b1;
      step();
      step();
      m_dx  = 8'h80;
      m_dy  = 8'h7F;
      reset = 1'b0;
      for (int f = 0; f < 4; f++) begin
         wait_valid("acc");
         step();
         check("acc_pos_x", {22'd0, pos_x}, ex_x[f]);
         check("acc_pos_y", {22'd0, pos_y}, ex_y[f]);
         if (f == 2) m_dx = 8'h7F;
      end

      // No mouse: pins float high
      m_off = 1'b1;
      for (int f = 0; f < 2; f++) begin
         wait_valid("nomouse");
         check("nomouse_dx",      {24'd0, dx},      32'hFF);
         check("nomouse_dy",      {24'd0, dy},      32'hFF);
         check("nomouse_buttons", {30'd0, buttons}, 32'd0);
      end

      // enable low from reset: no strobing at all
      enable = 1'b0;
      reset  = 1'b1;
      step();
      step();
      reset = 1'b0;
      e3    = n_edges;
      repeat (200) step();
      check("dis_no_edges", n_edges - e3,  32'd0);
      check("dis_stra",     {31'd0, stra}, 32'd0);
      check("dis_busy",     {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
